ds1302_slave: RTL and testbench

//  Synthesizable DS1302-compatible RTC responder: the device end of the 3-wire CE/SCLK/SIO link.

---
 rtl/ds1302_slave.sv | 184 ++++++++++++++++++
 tb/tb_ds1302_slave.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ds1302_slave.sv
// DS1302-compatible RTC responder: decodes CE/SCLK/SIO transfers from a master,
// serves clock-register reads, applies writes and keeps BCD hh:mm:ss running.
module ds1302_slave #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       RST,
  input  logic       SCLK,
  inout  wire        SIO,
  output logic [7:0] Sec_Out,
  output logic [7:0] Min_Out,
  output logic [7:0] Hour_Out,
  output logic       Write_Sig
);

  localparam int TW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_WDATA   = 3'd2,
    S_RDATA   = 3'd3,
    S_WAIT_CE = 3'd4
  } state_t;

  state_t          r_state, w_next;
  logic [1:0]      r_rst_sync;
  logic            w_rst_n;
  logic [2:0]      r_ce_s, r_sclk_s;
  logic [1:0]      r_sio_s;
  logic [7:0]      r_shift;
  logic [2:0]      r_bit_cnt;
  logic [2:0]      r_addr;
  logic [7:0]      r_rd_data;
  logic [3:0]      r_rd_cnt;
  logic            r_drive, r_sio_out, r_write_sig;
  logic [TW-1:0]   r_tick_cnt;
  logic [7:0]      r_regs [0:7];
  logic            w_sio_oe;

  // Async assert, release aligned to CLK.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) r_rst_sync <= 2'b00;
    else       r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  always_ff @(posedge CLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_ce_s   <= 3'b000;
      r_sclk_s <= 3'b000;
      r_sio_s  <= 2'b00;
    end else begin
      r_ce_s   <= {r_ce_s[1:0], RST};
      r_sclk_s <= {r_sclk_s[1:0], SCLK};
      r_sio_s  <= {r_sio_s[0], SIO};
    end
  end

  logic       w_ce, w_ce_rise, w_sclk_rise, w_sclk_fall, w_last_bit;
  logic       w_cmd_valid, w_commit, w_tick, w_time_wr;
  logic [7:0] w_shift_in;

  assign w_ce        = r_ce_s[1];
  assign w_ce_rise   = r_ce_s[1] & ~r_ce_s[2];
  assign w_sclk_rise = r_sclk_s[1] & ~r_sclk_s[2];
  assign w_sclk_fall = ~r_sclk_s[1] & r_sclk_s[2];
  assign w_shift_in  = {r_sio_s[1], r_shift[7:1]};
  assign w_last_bit  = w_sclk_rise && (r_bit_cnt == 3'd7);
  assign w_cmd_valid = w_shift_in[7] && !w_shift_in[6] && (w_shift_in[5:4] == 2'b00);
  assign w_commit    = (r_state == S_WDATA) && w_ce && w_last_bit &&
                       ((r_addr == 3'd7) || !r_regs[7][7]);
  assign w_tick      = (r_tick_cnt == TW'(CLK_FREQ - 1));
  assign w_time_wr   = w_commit && (r_addr <= 3'd2);

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'h9) return {v[7:4] + 4'h1, 4'h0};
    return {v[7:4], v[3:0] + 4'h1};
  endfunction

  always_ff @(posedge CLK or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // NOTE: every path assigns w_next first so the combinational block infers no latch.
  always_comb begin
    w_next = r_state;
    if (!w_ce) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (w_ce_rise) w_next = S_CMD;
        S_CMD:     if (w_last_bit)
                     w_next = !w_cmd_valid ? S_WAIT_CE : (w_shift_in[0] ? S_RDATA : S_WDATA);
        S_WDATA:   if (w_last_bit) w_next = S_WAIT_CE;
        S_RDATA:   if (w_sclk_fall && (r_rd_cnt == 4'd8)) w_next = S_WAIT_CE;
        S_WAIT_CE: w_next = S_WAIT_CE;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_sio_oe = 1'b0;
    if ((r_state == S_RDATA) && r_drive && w_ce) w_sio_oe = 1'b1;
  end
  assign SIO = w_sio_oe ? r_sio_out : 1'bz;

  // NOTE: state updates use <= so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_shift     <= 8'h00;
      r_bit_cnt   <= 3'd0;
      r_addr      <= 3'd0;
      r_rd_data   <= 8'h00;
      r_rd_cnt    <= 4'd0;
      r_drive     <= 1'b0;
      r_sio_out   <= 1'b0;
      r_write_sig <= 1'b0;
      r_tick_cnt  <= '0;
      // NOTE: the register file is small and has defined power-up values, so it is reset.
      for (int i = 0; i < 8; i++)
        r_regs[i] <= (i == 0 || i == 7) ? 8'h80 : (i >= 3 && i <= 5) ? 8'h01 : 8'h00;
    end else begin
      r_write_sig <= w_commit;

      if (!w_ce || (r_state == S_IDLE)) begin
        r_bit_cnt <= 3'd0;
        r_shift   <= 8'h00;
      end else if (((r_state == S_CMD) || (r_state == S_WDATA)) && w_sclk_rise) begin
        r_shift   <= w_shift_in;
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end

      if ((r_state == S_CMD) && w_ce && w_last_bit) begin
        r_addr    <= w_shift_in[3:1];
        r_rd_data <= r_regs[w_shift_in[3:1]];
        r_rd_cnt  <= 4'd0;
      end

      // Bit n goes out on fall n+1 of the read phase; the 9th fall releases SIO.
      if ((r_state == S_RDATA) && w_ce) begin
        if (w_sclk_fall) begin
          if (r_rd_cnt == 4'd8) begin
            r_drive <= 1'b0;
          end else begin
            r_drive   <= 1'b1;
            r_sio_out <= r_rd_data[r_rd_cnt[2:0]];
            r_rd_cnt  <= r_rd_cnt + 4'd1;
          end
        end
      end else begin
        r_drive <= 1'b0;
      end

      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);

      if (w_commit) r_regs[r_addr] <= w_shift_in;

      // A same-cycle write to sec/min/hour wins over the tick.
      if (w_tick && !r_regs[0][7] && !w_time_wr) begin
        if (r_regs[0] == 8'h59) begin
          r_regs[0] <= 8'h00;
          if (r_regs[1] == 8'h59) begin
            r_regs[1] <= 8'h00;
            r_regs[2] <= (r_regs[2] == 8'h23) ? 8'h00 : bcd_inc(r_regs[2]);
          end else begin
            r_regs[1] <= bcd_inc(r_regs[1]);
          end
        end else begin
          r_regs[0] <= bcd_inc(r_regs[0]);
        end
      end
    end
  end

  assign Sec_Out   = r_regs[0];
  assign Min_Out   = r_regs[1];
  assign Hour_Out  = r_regs[2];
  assign Write_Sig = r_write_sig;

endmodule

// File: tb/tb_ds1302_slave.sv
// Directed bench for ds1302_slave: protocol checks on a slow-tick instance,
// timekeeping rollover on a fast-tick instance.
module tb_ds1302_slave;

  localparam int H = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, sclk, ce_a, ce_b, tb_oe, tb_do;
  wire        sio_a, sio_b;
  logic [7:0] sec_a, min_a, hour_a, sec_b, min_b, hour_b;
  logic       ws_a, ws_b;

  assign sio_a = (tb_oe && ce_a) ? tb_do : 1'bz;
  assign sio_b = (tb_oe && ce_b) ? tb_do : 1'bz;
  pullup (sio_a);
  pullup (sio_b);

  ds1302_slave #(.CLK_FREQ(50_000)) u_a (
    .CLK(clk), .RSTn(rst_n), .RST(ce_a), .SCLK(sclk), .SIO(sio_a),
    .Sec_Out(sec_a), .Min_Out(min_a), .Hour_Out(hour_a), .Write_Sig(ws_a)
  );

  ds1302_slave #(.CLK_FREQ(10)) u_b (
    .CLK(clk), .RSTn(rst_n), .RST(ce_b), .SCLK(sclk), .SIO(sio_b),
    .Sec_Out(sec_b), .Min_Out(min_b), .Hour_Out(hour_b), .Write_Sig(ws_b)
  );

  int n_checks = 0;
  int n_errors = 0;
  int ws_cnt_a = 0;
  int ws_cnt_b = 0;

  always @(negedge clk) begin
    ws_cnt_a <= ws_cnt_a + int'(ws_a);
    ws_cnt_b <= ws_cnt_b + int'(ws_b);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ce(input int sel, input logic v);
    if (sel == 0) ce_a = v;
    else          ce_b = v;
  endtask

  task automatic send_bit(input logic b);
    tb_oe = 1'b1;
    tb_do = b;
    wait_clk(H);
    sclk = 1'b1;
    wait_clk(H);
    sclk = 1'b0;
  endtask

  task automatic xfer_write(input int sel, input logic [7:0] cmd, input logic [7:0] dat);
    set_ce(sel, 1'b1);
    wait_clk(H);
    for (int i = 0; i < 8; i++) send_bit(cmd[i]);
    for (int i = 0; i < 8; i++) send_bit(dat[i]);
    tb_oe = 1'b0;
    wait_clk(H);
    set_ce(sel, 1'b0);
    wait_clk(H);
  endtask

  // Sends the command bits up to the 8th fall, leaving SIO released for the slave.
  task automatic send_read_cmd(input logic [7:0] cmd);
    ce_a = 1'b1;
    wait_clk(H);
    for (int i = 0; i < 7; i++) send_bit(cmd[i]);
    tb_do = cmd[7];
    wait_clk(H);
    sclk = 1'b1;
    wait_clk(1);
    tb_oe = 1'b0;
    wait_clk(H - 1);
    sclk = 1'b0;
  endtask

  // drv counts samples where the slave drove SIO, including one after the 9th fall.
  task automatic xfer_read(input logic [7:0] cmd, output logic [7:0] dat,
                           output int drv, output int st);
    send_read_cmd(cmd);
    drv = 0;
    for (int i = 0; i < 8; i++) begin
      wait_clk(H);
      dat[i] = sio_a;
      if (u_a.w_sio_oe) drv++;
      sclk = 1'b1;
      wait_clk(H);
      sclk = 1'b0;
    end
    wait_clk(H);
    st = int'(u_a.r_state);
    if (u_a.w_sio_oe || (sio_a !== 1'b1)) drv++;
    ce_a = 1'b0;
    wait_clk(H);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

  logic [7:0] rd;
  int         drv, st, ws0;
  logic       seen;

  initial begin
    rst_n = 1'b0; sclk = 1'b0; ce_a = 1'b0; ce_b = 1'b0; tb_oe = 1'b0; tb_do = 1'b0;
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(5);

    check("reset_sec", sec_a, 8'h80);
    check("reset_min", min_a, 8'h00);
    check("reset_hour", hour_a, 8'h00);
    check("reset_write_sig", ws_a, 1'b0);
    check("reset_state", int'(u_a.r_state), 0);
    check("reset_sio_oe", u_a.w_sio_oe, 1'b0);
    xfer_read(8'h8F, rd, drv, st);
    check("reset_ctrl_read", rd, 8'h80);
    check("reset_ctrl_drv", drv, 8);
    xfer_read(8'h87, rd, drv, st);
    check("reset_date_read", rd, 8'h01);

    // Clear WP, then write seconds.
    ws0 = ws_cnt_a;
    xfer_write(0, 8'h8E, 8'h00);
    xfer_write(0, 8'h80, 8'h30);
    check("t1_write_pulses", ws_cnt_a - ws0, 2);
    check("t1_sec", sec_a, 8'h30);
    xfer_read(8'h8F, rd, drv, st);
    check("t1_ctrl", rd, 8'h00);

    xfer_read(8'h81, rd, drv, st);
    check("t2_read_sec", rd, 8'h30);
    check("t2_drive_count", drv, 8);
    check("t2_state_after", st, 4);
    check("t2_state_idle", int'(u_a.r_state), 0);

    // WP set blocks the minutes write.
    ws0 = ws_cnt_a;
    xfer_write(0, 8'h8E, 8'h80);
    xfer_write(0, 8'h82, 8'h45);
    check("t3_write_pulses", ws_cnt_a - ws0, 1);
    check("t3_min", min_a, 8'h00);

    xfer_write(0, 8'h8E, 8'h00);
    xfer_write(0, 8'h84, 8'h17);
    check("hour_write", hour_a, 8'h17);
    xfer_read(8'h85, rd, drv, st);
    check("hour_read", rd, 8'h17);

    // Abort a seconds write after 4 data bits.
    ws0 = ws_cnt_a;
    ce_a = 1'b1;
    wait_clk(H);
    for (int i = 0; i < 8; i++) send_bit(8'h80 >> i);
    for (int i = 0; i < 4; i++) send_bit(8'h12 >> i);
    tb_oe = 1'b0;
    ce_a = 1'b0;
    wait_clk(6);
    check("t4_sec", sec_a, 8'h30);
    check("t4_no_pulse", ws_cnt_a - ws0, 0);
    check("t4_sio_oe", u_a.w_sio_oe, 1'b0);
    check("t4_state", int'(u_a.r_state), 0);
    wait_clk(H);
    xfer_write(0, 8'h80, 8'h12);
    check("t4_clean_write", sec_a, 8'h12);

    // Unsupported commands: RAM, burst, out-of-range address.
    xfer_read(8'hC1, rd, drv, st);
    check("ram_cmd_drv", drv, 0);
    check("ram_cmd_state", st, 4);
    xfer_read(8'hBF, rd, drv, st);
    check("burst_cmd_drv", drv, 0);
    xfer_read(8'h91, rd, drv, st);
    check("addr8_cmd_drv", drv, 0);
    check("addr8_cmd_data", rd, 8'hFF);

    // Timekeeping on the fast instance.
    xfer_write(1, 8'h8E, 8'h00);
    xfer_write(1, 8'h84, 8'h23);
    xfer_write(1, 8'h82, 8'h59);
    check("t5_halted_sec", sec_b, 8'h80);
    check("t5_hour_set", hour_b, 8'h23);
    ce_b = 1'b1;
    wait_clk(H);
    for (int i = 0; i < 8; i++) send_bit(8'h80 >> i);
    for (int i = 0; i < 7; i++) send_bit(8'h59 >> i);
    tb_do = 1'b0;
    wait_clk(H);
    sclk = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      wait_clk(1);
      if (ws_b) seen = 1'b1;
    end
    check("t5_commit_seen", seen, 1'b1);
    check("t5_sec_at_commit", sec_b, 8'h59);
    check("t5_min_at_commit", min_b, 8'h59);
    wait_clk(10);
    check("t5_hour_roll", hour_b, 8'h00);
    check("t5_min_roll", min_b, 8'h00);
    check("t5_sec_roll", sec_b, 8'h00);
    wait_clk(10);
    check("t5_sec_next", sec_b, 8'h01);
    check("t5_hour_hold", hour_b, 8'h00);
    sclk = 1'b0;
    tb_oe = 1'b0;
    wait_clk(H);
    ce_b = 1'b0;
    wait_clk(H);

    // Reset in the middle of a read data phase.
    send_read_cmd(8'h81);
    wait_clk(H);
    check("t6_driving", u_a.w_sio_oe, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_sio_released", u_a.w_sio_oe, 1'b0);
    check("t6_sec", sec_a, 8'h80);
    check("t6_hour", hour_a, 8'h00);
    check("t6_state", int'(u_a.r_state), 0);
    wait_clk(2);
    ce_a = 1'b0;
    rst_n = 1'b1;
    wait_clk(H);
    xfer_read(8'h81, rd, drv, st);
    check("t6_read_sec", rd, 8'h80);
    check("t6_read_drv", drv, 8);
    xfer_read(8'h8F, rd, drv, st);
    check("t6_read_ctrl", rd, 8'h80);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
